// File: rtl/aac_frame_sequencer_pkg.sv
// Shared types and constants for the ADTS frame sequencer and its header parser.
package aac_seq_pkg;

  typedef enum logic [2:0] {
    HUNT0     = 3'd0,
    HUNT1     = 3'd1,
    HDR       = 3'd2,
    CHECK     = 3'd3,
    CRC       = 3'd4,
    START     = 3'd5,
    PAYLOAD   = 3'd6,
    WAIT_DONE = 3'd7
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LAYER   = 3'd1;
  localparam logic [2:0] ERR_SFI     = 3'd2;
  localparam logic [2:0] ERR_SHORT   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam int ADTS_HDR_LEN = 7;
  localparam int ADTS_CRC_LEN = 2;
  localparam int SFI_MAX      = 11;

  // Header length in bytes; the CRC word follows the fixed header when protection is on.
  function automatic logic [3:0] hdr_len(input logic prot_abs);
    return prot_abs ? 4'(ADTS_HDR_LEN) : 4'(ADTS_HDR_LEN + ADTS_CRC_LEN);
  endfunction

endpackage

// File: rtl/aac_frame_sequencer_hdr_parse.sv
// ADTS header field extraction: working registers filled byte by byte, a validity
// verdict for the CHECK cycle, and published fields that only change on commit.
module aac_adts_hdr_parse
  import aac_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync_we,
  input  logic        byte_we,
  input  logic [2:0]  byte_idx,
  input  logic [7:0]  data,
  input  logic        commit,
  output logic        prot_abs,
  output logic [2:0]  chk_code,
  output logic [12:0] pay_len,
  output logic [1:0]  hdr_profile,
  output logic [3:0]  hdr_sf_index,
  output logic [2:0]  hdr_ch_cfg,
  output logic [12:0] hdr_frame_len,
  output logic [1:0]  hdr_num_rdb
);

  logic [1:0]  layer_q, profile_q, rdb_q;
  logic        prot_q;
  logic [3:0]  sf_q;
  logic [2:0]  ch_q;
  logic [12:0] flen_q;
  logic [1:0]  pub_profile_q, pub_rdb_q;
  logic [3:0]  pub_sf_q;
  logic [2:0]  pub_ch_q;
  logic [12:0] pub_flen_q;
  logic [12:0] hl;

  assign hl = 13'(hdr_len(prot_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_q       <= '0;
      prot_q        <= 1'b0;
      profile_q     <= '0;
      sf_q          <= '0;
      ch_q          <= '0;
      flen_q        <= '0;
      rdb_q         <= '0;
      pub_profile_q <= '0;
      pub_sf_q      <= '0;
      pub_ch_q      <= '0;
      pub_flen_q    <= '0;
      pub_rdb_q     <= '0;
    end else begin
      if (sync_we) begin
        layer_q <= data[2:1];
        prot_q  <= data[0];
      end
      if (byte_we) begin
        case (byte_idx)
          3'd2: begin
            profile_q <= data[7:6];
            sf_q      <= data[5:2];
            ch_q[2]   <= data[0];
          end
          3'd3: begin
            ch_q[1:0]     <= data[7:6];
            flen_q[12:11] <= data[1:0];
          end
          3'd4: flen_q[10:3] <= data;
          3'd5: flen_q[2:0]  <= data[7:5];
          3'd6: rdb_q        <= data[1:0];
          default: ;
        endcase
      end
      if (commit) begin
        pub_profile_q <= profile_q;
        pub_sf_q      <= sf_q;
        pub_ch_q      <= ch_q;
        pub_flen_q    <= flen_q;
        pub_rdb_q     <= rdb_q;
      end
    end
  end

  // Priority: layer, then sampling-frequency index, then length too short for the header.
  always_comb begin
    chk_code = ERR_NONE;
    if (layer_q != 2'd0)             chk_code = ERR_LAYER;
    else if (sf_q > 4'(SFI_MAX))     chk_code = ERR_SFI;
    else if (flen_q < hl)            chk_code = ERR_SHORT;
  end

  assign prot_abs = prot_q;
  assign pay_len  = flen_q - hl;

  // Fields are visible during the hdr_valid cycle itself, then held from the published copy.
  assign hdr_profile   = commit ? profile_q : pub_profile_q;
  assign hdr_sf_index  = commit ? sf_q      : pub_sf_q;
  assign hdr_ch_cfg    = commit ? ch_q      : pub_ch_q;
  assign hdr_frame_len = commit ? flen_q    : pub_flen_q;
  assign hdr_num_rdb   = commit ? rdb_q     : pub_rdb_q;

endmodule

// File: rtl/aac_frame_sequencer.sv
// ADTS front-end: sync hunt, header parse/validate, decoder start, payload pass-through
// and completion wait with timeout. in_valid/in_ready and out_valid/out_ready: a byte moves on a cycle where valid and ready are both high.
module aac_frame_sequencer
  import aac_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             dec_start,
  input  logic             dec_done,
  output logic             dec_abort,
  output logic             hdr_valid,
  output logic [1:0]       hdr_profile,
  output logic [3:0]       hdr_sf_index,
  output logic [2:0]       hdr_ch_cfg,
  output logic [12:0]      hdr_frame_len,
  output logic [1:0]       hdr_num_rdb,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] frame_cnt,
  output state_t           dbg_state
);

  localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [12:0]       pay_cnt_q, pay_cnt_d;
  logic [19:0]       timer_q, timer_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              accept, sync_we, byte_we, commit, prot_abs;
  logic [2:0]        chk_code;
  logic [12:0]       pay_len;

  aac_adts_hdr_parse u_parse (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync_we       (sync_we),
    .byte_we       (byte_we),
    .byte_idx      (byte_cnt_q),
    .data          (in_data),
    .commit        (commit),
    .prot_abs      (prot_abs),
    .chk_code      (chk_code),
    .pay_len       (pay_len),
    .hdr_profile   (hdr_profile),
    .hdr_sf_index  (hdr_sf_index),
    .hdr_ch_cfg    (hdr_ch_cfg),
    .hdr_frame_len (hdr_frame_len),
    .hdr_num_rdb   (hdr_num_rdb)
  );

  always_comb begin
    in_ready = 1'b1;
    if (state_q == CHECK || state_q == START || state_q == WAIT_DONE) in_ready = 1'b0;
    else if (state_q == PAYLOAD)                                      in_ready = out_ready;
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT0;
      byte_cnt_q  <= '0;
      pay_cnt_q   <= '0;
      timer_q     <= '0;
      frame_cnt_q <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      timer_q     <= timer_d;
      frame_cnt_q <= frame_cnt_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    timer_d     = '0;
    frame_cnt_d = frame_cnt_q;
    err_code_d  = err_code_q;
    out_valid   = 1'b0;
    out_data    = '0;
    dec_start   = 1'b0;
    dec_abort   = 1'b0;
    hdr_valid   = 1'b0;
    err_valid   = 1'b0;
    sync_we     = 1'b0;
    byte_we     = 1'b0;
    commit      = 1'b0;
    case (state_q)
      HUNT0: if (accept && in_data == 8'hFF) state_d = HUNT1;
      HUNT1: begin
        // A repeated 0xFF may still be the first sync byte, so it wins over the 0xF? match.
        if (accept) begin
          if (in_data == 8'hFF) begin
            state_d = HUNT1;
          end else if (in_data[7:4] == 4'hF) begin
            sync_we    = 1'b1;
            byte_cnt_d = 3'd2;
            state_d    = HDR;
          end else begin
            state_d = HUNT0;
          end
        end
      end
      HDR: begin
        if (accept) begin
          byte_we    = 1'b1;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd6) state_d = CHECK;
        end
      end
      CHECK: begin
        if (chk_code != ERR_NONE) begin
          err_valid  = 1'b1;
          err_code_d = chk_code;
          state_d    = HUNT0;
        end else begin
          hdr_valid  = 1'b1;
          commit     = 1'b1;
          pay_cnt_d  = pay_len;
          byte_cnt_d = '0;
          state_d    = prot_abs ? START : CRC;
        end
      end
      CRC: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'(ADTS_CRC_LEN - 1)) state_d = START;
        end
      end
      START: begin
        dec_start = 1'b1;
        state_d   = (pay_cnt_q == 13'd0) ? WAIT_DONE : PAYLOAD;
      end
      PAYLOAD: begin
        out_valid = in_valid;
        out_data  = in_data;
        if (accept) begin
          pay_cnt_d = pay_cnt_q - 13'd1;
          if (pay_cnt_q == 13'd1) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_q + 20'd1;
        if (dec_done) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          timer_d     = '0;
          state_d     = HUNT0;
        end else if (timer_q == TIMER_LAST) begin
          dec_abort  = 1'b1;
          err_valid  = 1'b1;
          err_code_d = ERR_TIMEOUT;
          timer_d    = '0;
          state_d    = HUNT0;
        end
      end
      default: state_d = HUNT0;
    endcase
  end

  assign err_code  = err_code_d;
  assign frame_cnt = frame_cnt_q;
  assign dbg_state = state_q;

endmodule
